// File: rtl/pwm_carrier_bank_pkg.sv
// Shared types and widths for the PWM carrier bank.
// Carrier modes plus default bank geometry.
package pwm_carrier_bank_pkg;

  localparam int PWM_WIDTH      = 8;
  localparam int PWMCOUNT_WIDTH = 16;

  typedef enum logic {
    CARR_SAW = 1'b0,
    CARR_TRI = 1'b1
  } carr_mode_t;

endpackage

// File: rtl/pwm_carrier_bank_cnt.sv
// One carrier counter: start load, clamp, saw/tri stepping.
// Zero/peak flags are registered alongside the count.
import pwm_carrier_bank_pkg::*;

module pwm_carrier_cnt #(
  parameter int CNT_W = PWMCOUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             start,
  input  logic [CNT_W-1:0] period,
  input  carr_mode_t       mode,
  input  logic [CNT_W-1:0] phase,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             peak
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dn_q, dn_d;
  logic             zero_q, zero_d;
  logic             peak_q, peak_d;

  always_comb begin
    cnt_d = '0;
    dn_d  = 1'b0;
    if (!run) begin
      cnt_d = '0;
      dn_d  = 1'b0;
    end else if (start) begin
      cnt_d = (phase > period) ? period : phase;
      dn_d  = 1'b0;
    end else if (mode == CARR_SAW) begin
      dn_d  = dn_q;
      cnt_d = (cnt_q >= period) ? '0 : cnt_q + ONE;
    end else if (cnt_q > period) begin
      // period shrank under us: resume from the new peak, falling
      cnt_d = period;
      dn_d  = 1'b1;
    end else if (!dn_q) begin
      if (cnt_q == period) begin
        cnt_d = (period == '0) ? '0 : period - ONE;
        dn_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
        dn_d  = 1'b0;
      end
    end else begin
      if (cnt_q == '0) begin
        cnt_d = (period == '0) ? '0 : ONE;
        dn_d  = 1'b0;
      end else begin
        cnt_d = cnt_q - ONE;
        dn_d  = 1'b1;
      end
    end
    zero_d = run && (cnt_d == '0);
    peak_d = run && (cnt_d == period);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dn_q   <= 1'b0;
      zero_q <= 1'b0;
      peak_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dn_q   <= dn_d;
      zero_q <= zero_d;
      peak_q <= peak_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = zero_q;
  assign peak = peak_q;

endmodule

// File: rtl/pwm_carrier_bank.sv
// Bank of phase-shifted PWM carriers with double-buffered
// period/mode/mask, applied at the carrier-0 zero point.
import pwm_carrier_bank_pkg::*;

module pwm_carrier_bank #(
  parameter int CARR_NUM = PWM_WIDTH,
  parameter int CNT_W    = PWMCOUNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CNT_W-1:0]          cfg_period,
  input  logic                      cfg_mode,
  input  logic [CNT_W*CARR_NUM-1:0] cfg_phase,
  input  logic [CARR_NUM-1:0]       cfg_mask,
  input  logic                      cfg_load,
  output logic [CNT_W*CARR_NUM-1:0] out_carr,
  output logic [CARR_NUM-1:0]       out_mask,
  output logic [CARR_NUM-1:0]       zero_evt,
  output logic [CARR_NUM-1:0]       peak_evt,
  output logic                      load_pend
);

  logic                running_q, running_d;
  logic [CNT_W-1:0]    p_q, p_d;
  carr_mode_t          mode_q, mode_d;
  logic [CARR_NUM-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    sp_q, sp_d;
  carr_mode_t          smode_q, smode_d;
  logic [CARR_NUM-1:0] smask_q, smask_d;
  logic                load_pend_q, load_pend_d;
  logic [CARR_NUM-1:0] out_mask_q, out_mask_d;
  logic                apply;
  logic                start;

  always_comb begin
    // stopped banks take the shadow at once; running ones wait for carrier 0
    apply = load_pend_q &&
            (!running_q || (out_carr[CNT_W-1:0] == '0));
    p_d    = apply ? sp_q    : p_q;
    mode_d = apply ? smode_q : mode_q;
    mask_d = apply ? smask_q : mask_q;
    sp_d    = cfg_load ? cfg_period              : sp_q;
    smode_d = cfg_load ? carr_mode_t'(cfg_mode)  : smode_q;
    smask_d = cfg_load ? cfg_mask                : smask_q;
    load_pend_d = cfg_load || (load_pend_q && !apply);
    running_d   = en && (p_q != '0);
    start       = running_d && !running_q;
    out_mask_d  = running_d ? mask_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q   <= 1'b0;
      p_q         <= '0;
      mode_q      <= CARR_SAW;
      mask_q      <= '0;
      sp_q        <= '0;
      smode_q     <= CARR_SAW;
      smask_q     <= '0;
      load_pend_q <= 1'b0;
      out_mask_q  <= '0;
    end else begin
      running_q   <= running_d;
      p_q         <= p_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      sp_q        <= sp_d;
      smode_q     <= smode_d;
      smask_q     <= smask_d;
      load_pend_q <= load_pend_d;
      out_mask_q  <= out_mask_d;
    end
  end

  for (genvar k = 0; k < CARR_NUM; k++) begin : g_carr
    pwm_carrier_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .run    (running_d),
      .start  (start),
      .period (p_d),
      .mode   (mode_d),
      .phase  (cfg_phase[k*CNT_W +: CNT_W]),
      .cnt    (out_carr[k*CNT_W +: CNT_W]),
      .zero   (zero_evt[k]),
      .peak   (peak_evt[k])
    );
  end

  assign out_mask  = out_mask_q;
  assign load_pend = load_pend_q;

endmodule
